// File: rtl/icache_pkg.sv
// Shared types and default geometry for the direct-mapped instruction cache.
// Optional hit/miss counters in instr_cache are enabled by defining ICACHE_STATS_EN.
package icache_pkg;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned BYTE_OFF_W = 2;
  localparam int unsigned OFF_LSB    = BYTE_OFF_W;

  localparam int unsigned BLOCKS_DEF = 8;
  localparam int unsigned WORDS_DEF  = 4;
  localparam int unsigned ADDR_W_DEF = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    UPDATE = 2'd2
  } icache_state_e;

  // Tag is whatever remains of the used PC bits above byte, word and index fields.
  function automatic int unsigned tag_width(input int unsigned addr_w,
                                            input int unsigned words,
                                            input int unsigned blocks);
    return addr_w - BYTE_OFF_W - $clog2(words) - $clog2(blocks);
  endfunction

endpackage

// File: rtl/icache_line_array.sv
// Valid/tag/data storage for the instruction cache: one write port, one
// combinational read port; reset clears only the valid bits.
module icache_line_array
  import icache_pkg::*;
#(
  parameter int unsigned BLOCKS = BLOCKS_DEF,
  parameter int unsigned WORDS  = WORDS_DEF,
  parameter int unsigned TAG_W  = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [$clog2(BLOCKS)-1:0]  wr_idx,
  input  logic [TAG_W-1:0]           wr_tag,
  input  logic [WORD_W*WORDS-1:0]    wr_data,
  input  logic [$clog2(BLOCKS)-1:0]  rd_idx,
  output logic                       rd_valid,
  output logic [TAG_W-1:0]           rd_tag,
  output logic [WORD_W*WORDS-1:0]    rd_data
);

  logic [BLOCKS-1:0]        valid_q, valid_d;
  logic [TAG_W-1:0]         tag_q  [BLOCKS];
  logic [TAG_W-1:0]         tag_d  [BLOCKS];
  logic [WORD_W*WORDS-1:0]  data_q [BLOCKS];
  logic [WORD_W*WORDS-1:0]  data_d [BLOCKS];

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (wr_en) begin
      valid_d[wr_idx] = 1'b1;
      tag_d[wr_idx]   = wr_tag;
      data_d[wr_idx]  = wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  // Tag and data need no reset: they are only observed through a set valid bit.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/instr_cache.sv
// Direct-mapped, read-only instruction cache: combinational hit path, block refill FSM.
// Defining ICACHE_STATS_EN adds saturating HIT_COUNT / MISS_COUNT outputs.
module instr_cache
  import icache_pkg::*;
#(
  parameter int unsigned BLOCKS = BLOCKS_DEF,
  parameter int unsigned WORDS  = WORDS_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic                                       CLK,
  input  logic                                       RESET,
  input  logic [31:0]                                PC,
  output logic [31:0]                                INSTRUCTION,
  output logic                                       BUSYWAIT,
  output logic                                       MEM_READ,
  output logic [ADDR_W-BYTE_OFF_W-$clog2(WORDS)-1:0] MEM_ADDRESS,
  input  logic [WORD_W*WORDS-1:0]                    MEM_READDATA,
  input  logic                                       MEM_BUSYWAIT
`ifdef ICACHE_STATS_EN
  ,
  output logic [15:0]                                HIT_COUNT,
  output logic [15:0]                                MISS_COUNT
`endif
);

  localparam int unsigned OFF_W   = $clog2(WORDS);
  localparam int unsigned IDX_W   = $clog2(BLOCKS);
  localparam int unsigned TAG_W   = tag_width(ADDR_W, WORDS, BLOCKS);
  localparam int unsigned BLK_W   = TAG_W + IDX_W;
  localparam int unsigned IDX_LSB = OFF_LSB + OFF_W;
  localparam int unsigned TAG_LSB = IDX_LSB + IDX_W;

  logic [OFF_W-1:0] pc_off;
  logic [IDX_W-1:0] pc_idx;
  logic [TAG_W-1:0] pc_tag;
  logic             unused_pc;

  assign pc_off    = PC[IDX_LSB-1:OFF_LSB];
  assign pc_idx    = PC[TAG_LSB-1:IDX_LSB];
  assign pc_tag    = PC[ADDR_W-1:TAG_LSB];
  assign unused_pc = ^{PC[31:ADDR_W], PC[OFF_LSB-1:0]};

  icache_state_e             state_q, state_d;
  logic [BLK_W-1:0]          addr_q, addr_d;
  logic [WORD_W*WORDS-1:0]   fill_q, fill_d;
  logic                      line_we;
  logic                      busy;
  logic                      mem_rd;

  logic                      rd_valid;
  logic [TAG_W-1:0]          rd_tag;
  logic [WORD_W*WORDS-1:0]   rd_data;
  logic [WORDS-1:0][WORD_W-1:0] rd_words;
  logic                      hit;

  // The write port takes the block address latched at miss time, not the live PC.
  icache_line_array #(
    .BLOCKS (BLOCKS),
    .WORDS  (WORDS),
    .TAG_W  (TAG_W)
  ) u_lines (
    .clk      (CLK),
    .rst      (RESET),
    .wr_en    (line_we),
    .wr_idx   (addr_q[IDX_W-1:0]),
    .wr_tag   (addr_q[BLK_W-1:IDX_W]),
    .wr_data  (fill_q),
    .rd_idx   (pc_idx),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data)
  );

  assign hit      = rd_valid && (rd_tag == pc_tag);
  assign rd_words = rd_data;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      addr_q  <= '0;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      fill_q  <= fill_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    fill_d  = fill_q;
    line_we = 1'b0;
    busy    = 1'b0;
    mem_rd  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!hit) begin
          busy    = 1'b1;
          addr_d  = {pc_tag, pc_idx};
          state_d = FETCH;
        end
      end
      FETCH: begin
        busy   = 1'b1;
        mem_rd = 1'b1;
        if (!MEM_BUSYWAIT) begin
          fill_d  = MEM_READDATA;
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        busy    = 1'b1;
        line_we = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset forces the stall and memory request low even before the state settles.
  assign BUSYWAIT    = busy & ~RESET;
  assign MEM_READ    = mem_rd & ~RESET;
  assign MEM_ADDRESS = addr_q;
  assign INSTRUCTION = (hit && !RESET) ? rd_words[pc_off] : 32'h0;

`ifdef ICACHE_STATS_EN
  logic [15:0] hit_cnt_q, hit_cnt_d;
  logic [15:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (state_q == IDLE && hit && hit_cnt_q != 16'hFFFF)
      hit_cnt_d = hit_cnt_q + 16'd1;
    if (state_q == IDLE && !hit && miss_cnt_q != 16'hFFFF)
      miss_cnt_d = miss_cnt_q + 16'd1;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign HIT_COUNT  = hit_cnt_q;
  assign MISS_COUNT = miss_cnt_q;
`else
  // Statistics disabled: lookup results feed only the FSM and word select.
`endif

endmodule
